// File: rtl/conv_enc_k7.sv
// Rate-1/2, K=7 convolutional encoder with a registered code-pair output and valid/ready on both sides.
// Define TAIL_FLUSH_EN to append six zero-input tail pairs per frame; otherwise sr is cleared on the last bit.
module conv_enc_k7 #(
   parameter logic [6:0] G0 = 7'o171,
   parameter logic [6:0] G1 = 7'o133
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   input  logic       in_last,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [1:0] tx_pair,
   output logic       tx_last
);

   // state | meaning
   // IDLE  | between frames, sr = 0
   // DATA  | mid-frame, accepting information bits
   // TAIL  | flushing six zero inputs, input side stalled

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] TAIL = 2'd2;

   // Bit k of the reversed polynomial is the coefficient for delay k.
   localparam logic [6:0] G0_REV = {G0[0], G0[1], G0[2], G0[3], G0[4], G0[5], G0[6]};
   localparam logic [6:0] G1_REV = {G1[0], G1[1], G1[2], G1[3], G1[4], G1[5], G1[6]};

   logic [1:0] state;
   logic [5:0] sr;
   logic       out_free;
   logic       in_acc;
   logic       u;
   logic [6:0] taps;
   logic [1:0] pair_next;
`ifdef TAIL_FLUSH_EN
   logic [2:0] tail_cnt;
`endif

   assign out_free  = !tx_valid || tx_ready;
   assign in_ready  = (state != TAIL) && out_free;
   assign in_acc    = in_valid && in_ready;
   assign u         = (state == TAIL) ? 1'b0 : in_bit;
   assign taps      = {sr, u};
   assign pair_next = {^(taps & G1_REV), ^(taps & G0_REV)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sr       <= '0;
         tx_valid <= 1'b0;
         tx_pair  <= 2'b00;
         tx_last  <= 1'b0;
`ifdef TAIL_FLUSH_EN
         tail_cnt <= '0;
`endif
      end else begin
         if (in_acc) begin
            tx_valid <= 1'b1;
            tx_pair  <= pair_next;
`ifdef TAIL_FLUSH_EN
            tx_last  <= 1'b0;
            sr       <= {sr[4:0], in_bit};
            state    <= in_last ? TAIL : DATA;
            tail_cnt <= '0;
`else
            // Without a tail the next frame must still start from state 0.
            tx_last  <= in_last;
            sr       <= in_last ? 6'd0 : {sr[4:0], in_bit};
            state    <= in_last ? IDLE : DATA;
`endif
         end
`ifdef TAIL_FLUSH_EN
         else if (state == TAIL && out_free) begin
            tx_valid <= 1'b1;
            tx_pair  <= pair_next;
            if (tail_cnt == 3'd5) begin
               tx_last  <= 1'b1;
               sr       <= '0;
               state    <= IDLE;
               tail_cnt <= '0;
            end else begin
               tx_last  <= 1'b0;
               sr       <= {sr[4:0], 1'b0};
               tail_cnt <= tail_cnt + 3'd1;
            end
         end
`endif
         else if (tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_enc_k7.sv
// Bench for conv_enc_k7: table vectors, hand-written corner sequences and random traffic
// checked against a frame-level convolution model (follows the TAIL_FLUSH_EN build setting).
module tb_conv_enc_k7;

   localparam logic [6:0] G0 = 7'o171;
   localparam logic [6:0] G1 = 7'o133;
`ifdef TAIL_FLUSH_EN
   localparam int TAIL_LEN = 6;
`else
   localparam int TAIL_LEN = 0;
`endif
   localparam int LIMIT = 2000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       in_bit = 1'b0;
   logic       in_last = 1'b0;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [1:0] tx_pair;
   logic       tx_last;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic b;
      logic l;
   } src_t;

   typedef struct packed {
      logic [15:0] bits;
      logic [3:0]  len;
      logic [3:0]  npairs;
      logic [15:0] pairs;
   } vec_t;

   src_t       src_q[$];
   logic [2:0] exp_q[$];
   logic [2:0] rx_q[$];
   vec_t       tbl[3];
   int         first_acc, first_hs, last_hs, low_rdy;

   conv_enc_k7 #(.G0(G0), .G1(G1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_pair(tx_pair), .tx_last(tx_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Each output pair is the mod-2 sum of the frame bits weighted by the polynomial taps.
   task automatic add_model_frame(input logic [15:0] bits, input int n);
      int m;
      int a0;
      int a1;
      m = n + TAIL_LEN;
      for (int j = 0; j < n; j++) src_q.push_back('{b: bits[j], l: (j == n - 1)});
      for (int i = 0; i < m; i++) begin
         a0 = 0;
         a1 = 0;
         for (int k = 0; k < 7; k++) begin
            if (i - k >= 0 && i - k < n && bits[i - k]) begin
               if (G0[6 - k]) a0++;
               if (G1[6 - k]) a1++;
            end
         end
         exp_q.push_back({logic'(i == m - 1), logic'(a1 % 2), logic'(a0 % 2)});
      end
   endtask

   // mode 0: always ready, 1: random gaps on both sides, 2: tx_ready low for cycles 3..7
   task automatic run_stream(input int mode);
      int   idx;
      int   cyc;
      int   total;
      logic acc;
      logic prev_acc;
      logic prev_stall;
      logic [1:0] prev_pair;
      logic prev_last;
      idx = 0; cyc = 0; total = exp_q.size();
      prev_acc = 1'b0; prev_stall = 1'b0; prev_pair = 2'b00; prev_last = 1'b0;
      first_acc = -1; first_hs = -1; last_hs = -1; low_rdy = 0;
      rx_q.delete();
      while ((idx < src_q.size() || rx_q.size() < total) && cyc < LIMIT) begin
         @(negedge clk);
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 9) < 7);
            default: tx_ready = !(cyc >= 3 && cyc < 8);
         endcase
         if (idx < src_q.size()) begin
            if (prev_acc || !in_valid) in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_bit  = src_q[idx].b;
            in_last = src_q[idx].l;
         end else begin
            in_valid = 1'b0;
            in_bit   = 1'b0;
            in_last  = 1'b0;
         end
         #1;
         if (prev_stall)
            chk(tx_valid && tx_pair == prev_pair && tx_last == prev_last, "stall_hold",
                {tx_valid, tx_last, tx_pair}, {1'b1, prev_last, prev_pair});
         if (tx_valid && !tx_ready) chk(!in_ready, "stall_in_ready", in_ready, 0);
         if (!in_ready) low_rdy++;
         if (tx_valid && tx_ready) begin
            rx_q.push_back({tx_last, tx_pair});
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
         end
         acc = in_valid && in_ready;
         if (acc) begin
            if (first_acc < 0) first_acc = cyc;
            idx++;
         end
         prev_acc   = acc;
         prev_stall = tx_valid && !tx_ready;
         prev_pair  = tx_pair;
         prev_last  = tx_last;
         cyc++;
      end
      chk(cyc < LIMIT, "timeout", cyc, LIMIT);
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      tx_ready = 1'b1;
      #1 chk(!tx_valid, "drained", tx_valid, 0);
      src_q.delete();
   endtask

   task automatic compare_rx(input string tag);
      int n;
      chk(rx_q.size() == exp_q.size(), {tag, "_count"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk(rx_q[i] == exp_q[i], $sformatf("%s_pair%0d", tag, i), rx_q[i], exp_q[i]);
      exp_q.delete();
   endtask

   initial begin
      // pairs listed first-to-last from the MSB end, two bits each as {tx_pair[1], tx_pair[0]}
`ifdef TAIL_FLUSH_EN
      tbl[0] = '{bits: 16'h1, len: 4'd1, npairs: 4'd7, pairs: 16'b11_01_11_11_00_10_11_00};
      tbl[1] = '{bits: 16'h1, len: 4'd2, npairs: 4'd8, pairs: 16'b11_01_11_11_00_10_11_00};
      tbl[2] = '{bits: 16'h3, len: 4'd2, npairs: 4'd8, pairs: 16'b11_10_10_00_11_10_01_11};
`else
      tbl[0] = '{bits: 16'h1, len: 4'd1, npairs: 4'd1, pairs: 16'b11_00_00_00_00_00_00_00};
      tbl[1] = '{bits: 16'h1, len: 4'd2, npairs: 4'd2, pairs: 16'b11_01_00_00_00_00_00_00};
      tbl[2] = '{bits: 16'h3, len: 4'd2, npairs: 4'd2, pairs: 16'b11_10_00_00_00_00_00_00};
`endif

      repeat (2) @(negedge clk);
      #1;
      chk(tx_valid == 1'b0, "rst_tx_valid", tx_valid, 0);
      chk(tx_pair == 2'b00, "rst_tx_pair", tx_pair, 0);
      chk(tx_last == 1'b0, "rst_tx_last", tx_last, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);

      for (int t = 0; t < 3; t++) begin
         for (int j = 0; j < int'(tbl[t].len); j++)
            src_q.push_back('{b: tbl[t].bits[j], l: (j == int'(tbl[t].len) - 1)});
         for (int i = 0; i < int'(tbl[t].npairs); i++)
            exp_q.push_back({logic'(i == int'(tbl[t].npairs) - 1), tbl[t].pairs[15 - 2 * i -: 2]});
         run_stream(0);
         chk(first_hs == first_acc + 1, $sformatf("tbl%0d_latency", t), first_hs - first_acc, 1);
         chk(low_rdy == TAIL_LEN, $sformatf("tbl%0d_in_ready_low", t), low_rdy, TAIL_LEN);
         chk(last_hs - first_hs + 1 == rx_q.size(), $sformatf("tbl%0d_gapless", t),
             last_hs - first_hs + 1, rx_q.size());
         compare_rx($sformatf("tbl%0d", t));
      end

      add_model_frame(16'h1, 1);
      add_model_frame(16'h1, 1);
      run_stream(0);
      chk(last_hs - first_hs + 1 == rx_q.size(), "b2b_gapless", last_hs - first_hs + 1, rx_q.size());
      chk(low_rdy == 2 * TAIL_LEN, "b2b_in_ready_low", low_rdy, 2 * TAIL_LEN);
      compare_rx("b2b");

      add_model_frame(16'h00B5, 8);
      run_stream(2);
      compare_rx("bp");

      // abandon a frame with the output stalled (mid-TAIL when tails are enabled)
      @(negedge clk);
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0; tx_ready = 1'b1;
      @(negedge clk);
      in_last = (TAIL_LEN > 0);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; tx_ready = 1'b0;
      @(negedge clk);
      #1 chk(tx_valid, "pre_rst_valid", tx_valid, 1);
      #1 rst = 1'b1;
      #1 chk(!tx_valid && tx_pair == 2'b00 && !tx_last, "async_rst", {tx_valid, tx_last, tx_pair}, 0);
      @(negedge clk);
      rst = 1'b0;
      tx_ready = 1'b1;
      @(negedge clk);
      #1 chk(!tx_valid && in_ready, "post_rst_idle", {tx_valid, in_ready}, 1);
      add_model_frame(16'h1, 1);
      run_stream(0);
      compare_rx("post_rst");

      for (int r = 0; r < 6; r++) begin
         for (int f = 0; f < 4; f++) add_model_frame(16'($urandom), $urandom_range(1, 12));
         run_stream(1);
         compare_rx($sformatf("rand%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_enc_k7.md
# conv_enc_k7

Rate-1/2, constraint-length-7 convolutional encoder: the transmit-side counterpart of the 64-state Viterbi decoder. It accepts one information bit per handshake and emits one registered 2-bit code pair per handshake, with the same pair layout the decoder's branch-metric units consume. It sits between the bit source and the channel model or modulator, and terminates each frame so the decoder traceback ends in state 0.

## Interface
- G0, default 7'o171: generator polynomial producing tx_pair[0]; MSB weights the current input.
- G1, default 7'o133: generator polynomial producing tx_pair[1]; MSB weights the current input.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  in_bit/in_last are valid.
- in_ready  out  1  encoder accepts an input bit this cycle.
- in_bit  in  1  information bit.
- in_last  in  1  marks the final information bit of a frame.
- tx_valid  out  1  tx_pair/tx_last are valid.
- tx_ready  in  1  downstream accepts the pair this cycle.
- tx_pair  out  2  code pair: [0] = G0 output, [1] = G1 output.
- tx_last  out  1  marks the final pair of a frame.

## Operation
- Shift register sr[5:0] holds past inputs: sr[0] is 1 bit ago, sr[5] is 6 bits ago.
- Tap vector v = {sr[5:0], u}, so that v[k] is the input k bits ago and u is the current input.
- Coefficient for delay k is bit (6-k) of the polynomial.
- tx_pair[0] = XOR over k of v[k]·G0[6-k]; tx_pair[1] is the same with G1.
- On each input accept: sr <= {sr[4:0], u}.
- State machine (2 bits):
  - IDLE: sr = 0. The first accepted bit goes to DATA, or directly to end-of-frame handling if in_last=1.
  - DATA: accepts bits. An accepted bit with in_last=1 goes to TAIL (or to IDLE, see Configuration).
  - TAIL: in_ready=0. Six pairs are generated with u=0, counted by a 3-bit tail_cnt (0..5). The pair at tail_cnt=5 has tx_last=1. On its acceptance into the output register, sr is cleared and the state returns to IDLE.
- An output-register load (data or tail) happens only when the register is free: tx_valid=0, or tx_ready=1 in the same cycle.
- in_ready = (state != TAIL) && (!tx_valid || tx_ready).
- Backpressure: while tx_valid=1 and tx_ready=0, tx_pair, tx_last, sr, state and tail_cnt all hold.
- Reset mid-frame: the frame is abandoned, sr is cleared and the state goes to IDLE. No tail is generated.

## Timing
- Reset values: tx_valid=0, tx_pair=2'b00, tx_last=0, state=IDLE, sr=0, tail_cnt=0. in_ready=1 while rst is deasserted in IDLE.
- Latency: a bit accepted in cycle n produces tx_valid=1 with its pair in cycle n+1.
- Throughput: one pair per cycle while tx_ready=1, including back-to-back frames.
  - With tails, a frame of N bits takes N+6 cycles.
  - Without tails, it takes N cycles.
- The first tail pair loads in the cycle after the last-bit accept, provided the output register is free.
- A new frame's first bit can be accepted in the cycle the final tail pair is consumed.
- A simultaneous in_valid and tx_ready with tx_valid=1 is a handshake on both sides: the pair is consumed and the new pair is loaded in the same edge.
- in_valid held while in_ready=0 is ignored. The source holds its data until accepted.

## Configuration
- TAIL_FLUSH_EN:
  - Defined: the TAIL state is included as described. Frames end in encoder state 0 and each frame emits N+6 pairs.
  - Undefined: the TAIL state and tail_cnt are removed. The pair of the in_last bit carries tx_last=1, and sr is cleared to 0 on that accept, so the next frame starts from state 0. Each frame emits N pairs.

## Test plan
- Impulse (TAIL_FLUSH_EN defined): frame {1}, in_last=1, tx_ready=1 -> tx_pair sequence 11,01,11,11,00,10,11; tx_last only on the 7th pair; in_ready=0 for 6 cycles after the accept.
- Two bits {1,0}, last on the second bit -> 11,01 followed by tail 11,11,00,10,11,00; 8 pairs total; tx_last only on the 8th pair.
- Backpressure: tx_ready=0 for 5 cycles mid-frame -> tx_pair/tx_last stable and in_ready=0 throughout; no pair lost or duplicated; sequence identical to the tx_ready=1 case.
- Back-to-back frames {1} and {1} -> two identical 7-pair impulse sequences with no idle gap; the second frame is unaffected by the first.
- Reset pulse in the middle of the TAIL state -> tx_valid=0 immediately (asynchronous); the next frame {1} yields the impulse sequence from state 0.
- TAIL_FLUSH_EN undefined: frame {1,1}, last on the second bit -> 11,10 with tx_last on 10; the next frame {1} gives 11 with tx_last=1.
